// File: rtl/key_search_controller_if.sv
// Purpose: bundles the controller's start/result signals and its per-core range/handshake bus.
// Latency: none, wires only.
// Backpressure: none; cores report progress through core_done levels, not a ready signal.
interface key_search_controller_if #(
    parameter int NUM_CORES = 4
);
    // host side
    logic                      start;
    logic                      search_done;
    logic                      key_found;
    logic [23:0]               found_key;
    logic [2:0]                found_core;
    logic [31:0]               elapsed_cycles;

    // core side
    logic [NUM_CORES-1:0]      core_start;
    logic                      core_stop;
    logic [NUM_CORES-1:0]      core_done_ack;
    logic [NUM_CORES*24-1:0]   core_key_start;
    logic [NUM_CORES*24-1:0]   core_key_end;
    logic [NUM_CORES-1:0]      core_done;
    logic [NUM_CORES-1:0]      core_found;
    logic [NUM_CORES*24-1:0]   core_key;

    // controller view
    modport master (
        input  start,
        input  core_done,
        input  core_found,
        input  core_key,
        output core_start,
        output core_stop,
        output core_done_ack,
        output core_key_start,
        output core_key_end,
        output search_done,
        output key_found,
        output found_key,
        output found_core,
        output elapsed_cycles
    );

    // host + cores view
    modport slave (
        output start,
        output core_done,
        output core_found,
        output core_key,
        input  core_start,
        input  core_stop,
        input  core_done_ack,
        input  core_key_start,
        input  core_key_end,
        input  search_done,
        input  key_found,
        input  found_key,
        input  found_core,
        input  elapsed_cycles
    );
endinterface

// File: rtl/key_search_controller.sv
// Purpose: splits a key space across NUM_CORES search cores, picks the lowest-index hit, stops the rest.
// Latency: core_start two edges after start; results one edge after a hit; optional counter SEARCH_CYCLE_COUNT_EN.
// Backpressure: none; cores are polled via core_done levels, STOP_ALL waits until every core reports done.
module key_search_controller #(
    parameter int          NUM_CORES     = 4,
    parameter logic [23:0] KEY_SPACE_MAX = 24'h3FFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    key_search_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        PARTITION,
        LAUNCH,
        RUN,
        STOP_ALL,
        DONE
    } state_t;

    // 25-bit so that a full 24-bit key space (KEY_SPACE_MAX = FFFFFF) does not wrap to zero
    localparam logic [24:0] SPACE_SIZE = {1'b0, KEY_SPACE_MAX} + 25'd1;
    localparam logic [24:0] RANGE_SIZE = SPACE_SIZE / 25'(NUM_CORES);

    state_t                  state;
    logic [NUM_CORES-1:0]    done_seen;
    logic [NUM_CORES*24-1:0] range_start_nxt;
    logic [NUM_CORES*24-1:0] range_end_nxt;
    logic [NUM_CORES-1:0]    hit;
    logic                    any_hit;
    logic                    all_done;
    logic [2:0]              win_idx;
    logic [23:0]             win_key;

    // Static range table; the last core absorbs any remainder up to KEY_SPACE_MAX
    always_comb begin
        range_start_nxt = '0;
        range_end_nxt   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            range_start_nxt[i*24 +: 24] = 24'(25'(i) * RANGE_SIZE);
            if (i == NUM_CORES - 1)
                range_end_nxt[i*24 +: 24] = KEY_SPACE_MAX;
            else
                range_end_nxt[i*24 +: 24] = 24'(25'(i) * RANGE_SIZE + RANGE_SIZE - 25'd1);
        end
    end

    // Winner select: scanning downward leaves the lowest hitting index in win_idx/win_key
    always_comb begin
        hit      = bus.core_done & bus.core_found;
        any_hit  = |hit;
        all_done = &bus.core_done;
        win_idx  = '0;
        win_key  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_idx = 3'(i);
                win_key = bus.core_key[i*24 +: 24];
            end
        end
    end

    // Search sequencing with every output registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            done_seen          <= '0;
            bus.core_start     <= '0;
            bus.core_stop      <= 1'b0;
            bus.core_done_ack  <= '0;
            bus.core_key_start <= '0;
            bus.core_key_end   <= '0;
            bus.search_done    <= 1'b0;
            bus.key_found      <= 1'b0;
            bus.found_key      <= '0;
            bus.found_core     <= '0;
        end else begin
            bus.core_start    <= '0;
            bus.core_done_ack <= '0;
            case (state)
                IDLE: begin
                    if (bus.start)
                        state <= PARTITION;
                end
                PARTITION: begin
                    bus.core_key_start <= range_start_nxt;
                    bus.core_key_end   <= range_end_nxt;
                    bus.core_start     <= '1;
                    done_seen          <= '0;
                    state              <= LAUNCH;
                end
                LAUNCH: begin
                    state <= RUN;
                end
                RUN: begin
                    bus.core_done_ack <= bus.core_done & ~done_seen;
                    done_seen         <= done_seen | bus.core_done;
                    // a hit outranks all-done in the same cycle
                    if (any_hit) begin
                        bus.key_found  <= 1'b1;
                        bus.found_key  <= win_key;
                        bus.found_core <= win_idx;
                        bus.core_stop  <= 1'b1;
                        state          <= STOP_ALL;
                    end else if (all_done) begin
                        bus.search_done <= 1'b1;
                        state           <= DONE;
                    end
                end
                STOP_ALL: begin
                    bus.core_done_ack <= bus.core_done & ~done_seen;
                    done_seen         <= done_seen | bus.core_done;
                    if (all_done) begin
                        bus.core_stop   <= 1'b0;
                        bus.search_done <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    // terminal until reset; start is ignored
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEARCH_CYCLE_COUNT_EN
    // Search duration: cleared at launch, counts RUN/STOP_ALL cycles, saturates, frozen otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.elapsed_cycles <= '0;
        end else if (state == LAUNCH) begin
            bus.elapsed_cycles <= '0;
        end else if ((state == RUN || state == STOP_ALL) && bus.elapsed_cycles != 32'hFFFF_FFFF) begin
            bus.elapsed_cycles <= bus.elapsed_cycles + 32'd1;
        end
    end
`else
    assign bus.elapsed_cycles = '0;
`endif

endmodule

// File: doc/key_search_controller.md
KEY_SEARCH_CONTROLLER -- requirements
Module: key_search_controller

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, which sets the number of parallel datapath cores (power of two, 1..8).
REQ-002 The block SHALL have parameter KEY_SPACE_MAX, default 24'h3FFFFF, which is the last key searched.
REQ-003 The block SHALL have clk, input, 1, the single clock.
REQ-004 The block SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have start, input, 1, the search request, level-sampled in IDLE.
REQ-006 The block SHALL have core_start, output, NUM_CORES, a per-core start pulse.
REQ-007 The block SHALL have core_stop, output, 1, a broadcast abort to all cores.
REQ-008 The block SHALL have core_done_ack, output, NUM_CORES, a per-core acknowledge.
REQ-009 The block SHALL have core_key_start, output, NUM_CORES*24, the per-core first key, with core i in bits [24i+23:24i].
REQ-010 The block SHALL have core_key_end, output, NUM_CORES*24, the per-core last key, packed like core_key_start.
REQ-011 The block SHALL have core_done, input, NUM_CORES, the per-core done level.
REQ-012 The block SHALL have core_found, input, NUM_CORES, the per-core valid-message flag.
REQ-013 The block SHALL have core_key, input, NUM_CORES*24, the per-core current secret key.
REQ-014 The block SHALL have search_done, output, 1, high once the search has ended.
REQ-015 The block SHALL have key_found, output, 1, high if a key was found.
REQ-016 The block SHALL have found_key, output, 24, the winning key.
REQ-017 The block SHALL have found_core, output, 3, the index of the winning core.
REQ-018 The block SHALL have elapsed_cycles, output, 32, the search duration (see Configuration).

Function
REQ-019 The FSM SHALL have exactly the states IDLE, PARTITION, LAUNCH, RUN, STOP_ALL and DONE.
REQ-020 In IDLE, when start=1, the FSM SHALL go to PARTITION on the next edge; otherwise it SHALL stay in IDLE.
REQ-021 PARTITION SHALL register the ranges, with size=(KEY_SPACE_MAX+1)/NUM_CORES, start_i=i*size and end_i=start_i+size-1; the last core SHALL get end=KEY_SPACE_MAX; the FSM SHALL then go to LAUNCH.
REQ-022 LAUNCH SHALL drive core_start to all ones for exactly one cycle and then go to RUN; the ranges SHALL already be stable in that cycle.
REQ-023 A core counts as a hit when core_done[i]=1 and core_found[i]=1 in the same cycle.
REQ-024 In RUN, on any hit, the block SHALL take the lowest-index hitting core as the winner.
REQ-025 On a winner, the block SHALL latch found_key=core_key[i], found_core=i and key_found=1, and go to STOP_ALL.
REQ-026 In RUN, with all core_done=1 and no hit, the block SHALL go to DONE with key_found=0.
REQ-027 Hit detection SHALL take priority over the all-done condition in the same cycle.
REQ-028 STOP_ALL SHALL hold core_stop=1 until all core_done=1, then go to DONE; core_stop SHALL be 0 in every other state.
REQ-029 core_done_ack[i] SHALL pulse for one cycle on the first cycle core_done[i] is observed high after LAUNCH, once per core per search.
REQ-030 DONE SHALL hold search_done=1 and the latched results; the state is terminal until reset, and start is ignored there.
REQ-031 found_key, found_core and key_found SHALL change only on the winner-latch cycle.
REQ-032 Range arithmetic SHALL be 25-bit internally to avoid overflow when KEY_SPACE_MAX=24'hFFFFFF.
REQ-033 Outputs SHALL be registered and free of combinational paths from core inputs.

Reset
REQ-034 On reset_n=0, the block SHALL asynchronously enter IDLE.
REQ-035 On reset_n=0, all outputs, including the range buses, SHALL go to 0.
REQ-036 A reset mid-search SHALL discard all results; cores are reset by the same reset_n.

Configuration
REQ-037 With SEARCH_CYCLE_COUNT_EN defined, elapsed_cycles SHALL clear in LAUNCH and increment by 1 each cycle in RUN and STOP_ALL.
REQ-038 With SEARCH_CYCLE_COUNT_EN defined, elapsed_cycles SHALL freeze in DONE and saturate at 32'hFFFFFFFF.
REQ-039 Without SEARCH_CYCLE_COUNT_EN, elapsed_cycles SHALL be tied to 0 and no counter SHALL be synthesized.

Verification
REQ-040 NUM_CORES=4, start=1 -> ranges 000000-0FFFFF, 100000-1FFFFF, 200000-2FFFFF, 300000-3FFFFF, with core_start=4'b1111 for one cycle, two cycles after start.
REQ-041 Core 2 asserts done+found with key 24'h2A0013 -> key_found=1, found_key=2A0013, found_core=2, core_stop=1 until all done, then search_done=1.
REQ-042 Cores 1 and 3 hit in the same cycle -> found_core=1 and found_key equals core 1's key.
REQ-043 All cores assert done with found=0 -> search_done=1, key_found=0, core_stop never asserted.
REQ-044 reset_n=0 for one cycle during RUN -> all outputs 0 immediately; a new start relaunches from PARTITION.
REQ-045 SEARCH_CYCLE_COUNT_EN defined, cores done 100 cycles after LAUNCH with no hit -> elapsed_cycles=100 and stable in DONE.
